div: RTL
========

DIV -- requirements
Module: div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width; s is 2*WIDTH bits wide.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a request to begin a division, sampled on the rising clk edge.
REQ-005 SHALL have port in_is_signed, input, 1: 1 = two's-complement divide, 0 = unsigned divide; captured with start.
REQ-006 SHALL have port in_a, input, WIDTH, the dividend; captured with start.
REQ-007 SHALL have port in_b, input, WIDTH, the divisor; captured with start.
REQ-008 SHALL have port busy, output, 1, high while a division is in progress.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse marking s valid.
REQ-010 SHALL have port s, output, 2*WIDTH, the result {remainder, quotient}: upper half is HI/remainder, lower half is LO/quotient.

Function
REQ-011 SHALL implement the states IDLE, RUN, FIX and DONE.
REQ-012 SHALL accept start only in IDLE or DONE: capture in_a, in_b and in_is_signed, clear the iteration counter, and go to RUN.
REQ-013 SHALL ignore start while in RUN or FIX, leaving captured operands untouched.
REQ-014 SHALL, in RUN, perform one restoring shift-subtract step per cycle on operand magnitudes, for exactly WIDTH cycles, then go to FIX.
REQ-015 SHALL take magnitudes as follows in signed mode: |in_a| and |in_b|, with a negative operand negated modulo 2^WIDTH; unsigned mode uses raw values.
REQ-016 SHALL, in FIX, apply signs in signed mode: quotient negated iff the operand signs differ (truncation toward zero); remainder takes the sign of the dividend.
REQ-017 SHALL handle signed overflow (in_a = most-negative, in_b = -1) without special casing: quotient = 0x80000000 and remainder = 0 for WIDTH = 32.
REQ-018 SHALL, on divide by zero (in_b = 0, either mode), set quotient = all ones and remainder = the captured in_a, with unchanged latency.
REQ-019 SHALL, in FIX, write s and go to DONE; DONE lasts one cycle, then returns to IDLE unless start is accepted there.
REQ-020 SHALL have a latency of WIDTH+2 clocks: start sampled at edge N means s is updated and done = 1 after edge N+WIDTH+2, for exactly one cycle.
REQ-021 SHALL drive busy = 1 in RUN and FIX only; busy = 0 in IDLE and DONE.
REQ-022 SHALL hold s stable from the FIX write until the next FIX write, including across IDLE periods and a new start.
REQ-023 SHALL, for back-to-back operation with start accepted in DONE, start the next RUN on the following cycle and have done low in that cycle.
REQ-024 SHALL never assert done and busy together.

Reset
REQ-025 SHALL, while rst_n = 0, force asynchronously: state = IDLE, busy = 0, done = 0, s = 0, counter = 0, captured operands = 0.
REQ-026 SHALL, if reset is asserted mid-operation, abandon the division with no done pulse and no change to s beyond clearing to 0.
REQ-027 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; start sampled at that edge is accepted.

Verification
REQ-028 Bench SHALL cover unsigned: in_a = 100, in_b = 7 -> after 34 clocks done = 1, s = 0x00000002_0000000E.
REQ-029 Bench SHALL cover signed: in_a = 0xFFFFFFF9 (-7), in_b = 2 -> s = 0xFFFFFFFF_FFFFFFFD (r = -1, q = -3); the same operands unsigned -> s = 0x00000001_7FFFFFFC.
REQ-030 Bench SHALL cover signed overflow: in_a = 0x80000000, in_b = 0xFFFFFFFF -> s = 0x00000000_80000000, done after 34 clocks.
REQ-031 Bench SHALL cover divide by zero: in_a = 0x12345678, in_b = 0, either mode -> s = 0x12345678_FFFFFFFF at the normal latency.
REQ-032 Bench SHALL cover a start pulse during RUN with different operands -> ignored, and the first result is unchanged.
REQ-033 Bench SHALL cover rst_n low at RUN cycle 10 -> busy = 0, s = 0, and no done pulse; after release, 100/7 yields the REQ-028 result.

Source files
------------

// File: rtl/div.sv
// Multi-cycle restoring divider: one shift-subtract step per clock on operand
// magnitudes, then a sign-fix cycle. Result is s = {remainder, quotient}.
module div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_is_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] s
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_sgn;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvs;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_s;

  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_a_neg  = r_sgn & r_a[WIDTH-1];
  assign w_b_neg  = r_sgn & r_b[WIDTH-1];
  assign w_b_zero = (r_b == '0);
  // Negation is modulo 2^WIDTH, so the most-negative value maps onto itself
  // and still reads correctly as an unsigned magnitude.
  assign w_a_mag  = w_a_neg ? (~r_a + 1'b1) : r_a;
  assign w_b_mag  = w_b_neg ? (~r_b + 1'b1) : r_b;

  // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shift.
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_dvs};
  assign w_ge     = (w_shift >= {1'b0, r_dvs});

  assign w_quo_fix = (w_a_neg ^ w_b_neg) ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_fix = w_a_neg ? (~r_rem + 1'b1) : r_rem;

  // NOTE: every register in this block uses <= so all of them see the values
  // from before the edge; a blocking = here would chain updates within a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sgn   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_s     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_sgn   <= in_is_signed;
            r_a     <= in_a;
            r_b     <= in_b;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          // Count 0 loads magnitudes; counts 1..WIDTH are the division steps.
          if (r_cnt == '0) begin
            r_rem <= '0;
            r_quo <= w_a_mag;
            r_dvs <= w_b_mag;
          end else begin
            r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH)) r_state <= FIX;
        end
        FIX: begin
          r_s     <= w_b_zero ? {r_a, {WIDTH{1'b1}}} : {w_rem_fix, w_quo_fix};
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign s    = r_s;

endmodule
